// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with read-modify-write sub-word stores; define MAU_ALIGN_CHECK_EN to reject misaligned half/word accesses
`ifndef ADDR_BYTES
`define ADDR_BYTES 10
`endif
module mem_access_unit #(
  parameter int ADDR_BYTES = `ADDR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wena,
  output logic                  mem_rena,
  output logic [ADDR_BYTES-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RESP} state_t;
  state_t state, state_nx;
  logic r_we, r_signed;
  logic [1:0] r_size;
  logic [ADDR_BYTES+1:0] r_addr;
  logic [31:0] r_wdata, r_rdata, ld_data, st_data;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic req_bad, unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BYTES+2];
`ifdef MAU_ALIGN_CHECK_EN
  assign req_bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign req_bad = req_size == 2'b11;
`endif
  // state register; reset aborts any in-flight request
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state and memory/handshake outputs decoded from state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = req_bad ? RESP : !req_we ? RD : req_size == 2'b10 ? WR : RMW_RD;
      RD:      state_nx = RESP;
      RMW_RD:  state_nx = WR;
      WR:      state_nx = RESP;
      default: state_nx = IDLE;
    endcase
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    mem_rena = state == RD || state == RMW_RD;
    mem_wena = state == WR && r_we;
    mem_addr = state == IDLE ? '0 : r_addr[ADDR_BYTES+1:2];
    mem_wdata = state == WR ? st_data : '0;
  end
  // load lane extraction with extension, and store lane merge into the read word
  always_comb begin
    ld_b = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    ld_h = mem_rdata[{r_addr[1], 4'b0000} +: 16];
    ld_data = r_size == 2'b00 ? {{24{r_signed & ld_b[7]}}, ld_b} :
              r_size == 2'b01 ? {{16{r_signed & ld_h[15]}}, ld_h} : mem_rdata;
    st_data = r_size == 2'b10 ? r_wdata : r_rdata;
    if (r_size == 2'b00) st_data[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    if (r_size == 2'b01) st_data[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end
  // request capture, read-modify-write capture and response registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we <= 1'b0;
      r_size <= 2'b00;
      r_signed <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_we <= req_we;
        r_size <= req_size;
        r_signed <= req_signed;
        r_addr <= req_addr[ADDR_BYTES+1:0];
        r_wdata <= req_wdata;
        if (req_bad) begin
          resp_rdata <= '0;
          resp_err <= 1'b1;
        end
      end
      if (state == RD) begin
        resp_rdata <= ld_data;
        resp_err <= 1'b0;
      end
      if (state == RMW_RD) r_rdata <= mem_rdata;
      if (state == WR) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors, reset-abort sequence and randomized ops against a word-array reference model
module tb_mem_access_unit;
  localparam int AW = 10;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid, req_ready, req_we, req_signed;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic mem_wena, mem_rena;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [1<<AW];
  logic [31:0] ref_mem [1<<AW];
  logic mem_init;
  logic [AW-1:0] exp_idx;
  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, addr_bad = 0;

  typedef struct {
    logic we; logic [1:0] size; logic sgn; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic err; int lat; int rd; int wr; logic [31:0] w4;
  } vec_t;
  vec_t tv[14];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BYTES(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wena(mem_wena), .mem_rena(mem_rena), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  assign mem_rdata = mem_rena ? mem[mem_addr] : 32'h0;

  always @(posedge clk)
    if (mem_init) for (int i = 0; i < (1<<AW); i++) mem[i] <= init_word(i);
    else if (mem_wena) mem[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_rena) rd_cnt++;
    if (mem_wena) wr_cnt++;
    if ((mem_rena || mem_wena) && mem_addr != exp_idx) addr_bad++;
  end

  initial begin
    #3000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: memory as a word array, lanes picked by shift/mask arithmetic
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat, output int rd, output int wr);
    int unsigned w, sh, mask, v, idx;
    logic mis;
    idx = (addr >> 2) & ((32'd1 << AW) - 1);
    sh = 8 * (addr % 4);
    if (size == 2'd1) sh = 16 * ((addr / 2) % 2);
    mis = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
    mis = (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`endif
    w = ref_mem[idx];
    rdata = 0; err = 0; lat = 2; rd = 1; wr = 0;
    if (size == 2'd3 || mis) begin
      err = 1; lat = 1; rd = 0;
    end else if (size == 2'd2) begin
      if (we) begin ref_mem[idx] = wdata; rd = 0; wr = 1; end
      else rdata = w;
    end else begin
      mask = size == 2'd0 ? 32'hFF : 32'hFFFF;
      if (we) begin
        ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        wr = 1; lat = 3;
      end else begin
        v = (w >> sh) & mask;
        if (sgn && v > mask / 2) v = v | ~mask;
        rdata = v;
      end
    end
  endtask

  task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rd, output int wr, output logic [31:0] hold);
    int r0, w0, g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 10) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    exp_idx = addr[AW+1:2];
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    if (!resp_valid) lat = 99;
    rdata = resp_rdata; err = resp_err;
    @(posedge clk); #1;
    chk("resp_single_pulse", 32'(resp_valid), 32'd0);
    hold = resp_rdata;
    rd = rd_cnt - r0; wr = wr_cnt - w0;
  endtask

  logic we, sgn, a_err, e_err;
  logic [1:0] size;
  logic [31:0] addr, wdata, a_rd, e_rd, a_hold, w_before;
  int a_lat, e_lat, a_r, e_r, a_w, e_w, seen;

  initial begin
    tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tv[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 32'h0,        1'b0, 3, 1, 1, 32'hDEAABEEF};
    tv[3]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1, 32'h80FF7F01};
    tv[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h80FF7F01};
    tv[5]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'h80FF7F01};
    tv[6]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h00007F01, 1'b0, 2, 1, 0, 32'h80FF7F01};
    tv[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h80FF7F01};
    tv[8]  = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h80FF7F01};
`ifdef MAU_ALIGN_CHECK_EN
    tv[9]  = '{1'b0, 2'd1, 1'b1, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h80FF7F01};
    tv[10] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h80FF7F01};
`else
    tv[9]  = '{1'b0, 2'd1, 1'b1, 32'h11, 32'h0,        32'h00007F01, 1'b0, 2, 1, 0, 32'h80FF7F01};
    tv[10] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0, 32'h80FF7F01};
`endif
    tv[11] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD5555, 32'h0,        1'b0, 3, 1, 1, 32'h55557F01};
    tv[12] = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 32'h55557F01};
    tv[13] = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0, 32'h55557F01};

    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_word(i);
    mem_init = 1'b1; exp_idx = '0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wena", 32'(mem_wena), 32'd0);
    chk("rst_mem_rena", 32'(mem_rena), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, e_rd, e_err, e_lat, e_r, e_w);
      run_op(tv[i].we, tv[i].size, tv[i].sgn, tv[i].addr, tv[i].wdata, a_rd, a_err, a_lat, a_r, a_w, a_hold);
      chk($sformatf("vec%0d_rdata", i), a_rd, tv[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(tv[i].err));
      chk($sformatf("vec%0d_latency", i), a_lat, tv[i].lat);
      chk($sformatf("vec%0d_reads", i), a_r, tv[i].rd);
      chk($sformatf("vec%0d_writes", i), a_w, tv[i].wr);
      chk($sformatf("vec%0d_hold", i), a_hold, tv[i].rdata);
      chk($sformatf("vec%0d_word4", i), mem[4], tv[i].w4);
    end

    w_before = ref_mem[5];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h14; req_wdata = 32'h00000077;
    exp_idx = 5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_rmw_read", 32'(mem_rena), 32'd1);
    @(posedge clk); #1;
    chk("abort_in_wr", 32'(mem_wena), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_wena_dropped", 32'(mem_wena), 32'd0);
    chk("abort_ready_in_rst", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    chk("abort_word_unchanged", mem[5], w_before);
    chk("abort_ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      if (size == 2'd3 && $urandom_range(0, 3) != 0) size = 2'($urandom_range(0, 2));
      sgn = 1'($urandom);
      addr = $urandom_range(0, 63);
      wdata = $urandom;
      model(we, size, sgn, addr, wdata, e_rd, e_err, e_lat, e_r, e_w);
      run_op(we, size, sgn, addr, wdata, a_rd, a_err, a_lat, a_r, a_w, a_hold);
      chk($sformatf("rnd%0d_rdata", i), a_rd, e_rd);
      chk($sformatf("rnd%0d_err", i), 32'(a_err), 32'(e_err));
      chk($sformatf("rnd%0d_latency", i), a_lat, e_lat);
      chk($sformatf("rnd%0d_reads", i), a_r, e_r);
      chk($sformatf("rnd%0d_writes", i), a_w, e_w);
      chk($sformatf("rnd%0d_hold", i), a_hold, e_rd);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("final_word%0d", i), mem[i], ref_mem[i]);
    chk("mem_addr_during_access", addr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default `ADDR_BYTES from defines.vh, width of the word-index address driven to data memory.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=store), req_size in 2 (00 byte, 01 half, 10 word, 11 reserved), req_signed in 1 (load sign-extend), req_addr in 32 (byte address), req_wdata in 32.
REQ-005 SHALL have ports resp_valid out 1, resp_rdata out 32, resp_err out 1.
REQ-006 SHALL have memory-side ports mem_wena out 1, mem_rena out 1, mem_addr out ADDR_BYTES (word index), mem_wdata out 32, mem_rdata in 32 (combinational read, valid only while mem_rena=1, write on rising edge).

Function
REQ-007 SHALL implement FSM states IDLE, RD, WR, RMW_RD, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, registering we/size/signed/addr/wdata; request fields are ignored at all other times.
REQ-009 SHALL transition IDLE->RD for loads, IDLE->WR for word stores, IDLE->RMW_RD for byte/half stores.
REQ-010 SHALL, in RD and RMW_RD, drive mem_rena=1 and capture mem_rdata at the cycle end; mem_rena=0 in all other states.
REQ-011 SHALL, in WR, drive mem_wena=1 for exactly one cycle with mem_wdata = word (word store) or captured word with target lane(s) replaced (sub-word store); mem_wena=0 otherwise.
REQ-012 SHALL transition RD->RESP, RMW_RD->WR, WR->RESP, RESP->IDLE.
REQ-013 SHALL drive mem_addr = registered addr[ADDR_BYTES+1:2] while not in IDLE, 0 in IDLE.
REQ-014 SHALL use little-endian lanes: byte n at bits 8n+7:8n; halfword at addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16.
REQ-015 SHALL, for loads, extract the lane(s) and zero- or sign-extend per req_signed; word loads return mem_rdata unmodified.
REQ-016 SHALL pulse resp_valid for exactly one cycle in RESP; resp_rdata valid then (0 for stores), held otherwise at last value; no response backpressure.
REQ-017 SHALL give latency from accept edge to resp_valid: loads 2 cycles, word stores 2, sub-word stores 3; back-to-back requests accepted every RESP->IDLE turnaround (next accept earliest one cycle after resp_valid).
REQ-018 SHALL treat req_size=11 as an error: no memory access, IDLE->RESP, resp_err=1.
REQ-019 SHALL keep req_wdata bits outside the target lane(s) unused for sub-word stores.

Reset
REQ-020 SHALL, while rst=0, force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wena=0, mem_rena=0, mem_addr=0, mem_wdata=0, all registered request fields 0.
REQ-021 SHALL abort any in-flight request on reset with no write issued after reset assertion and no response after release.

Configuration
REQ-022 SHALL, with macro MAU_ALIGN_CHECK_EN defined, flag halfword with addr[0]=1 or word with addr[1:0]!=00 as misaligned: no memory access, IDLE->RESP, resp_err=1, resp_rdata=0.
REQ-023 SHALL, without MAU_ALIGN_CHECK_EN, ignore addr[0] for halfword and addr[1:0] for word (access forced aligned), resp_err=1 only for size=11.

Verification
REQ-024 Word store addr=0x10 data=0xDEADBEEF, then word load 0x10 -> mem_wena pulse with mem_addr=4; load resp_rdata=0xDEADBEEF two cycles after accept, resp_err=0.
REQ-025 Memory word 4 = 0xDEADBEEF, byte store addr=0x12 data=0x000000AA -> RMW_RD then WR, mem_wdata=0xDEAABEEF, resp_valid 3 cycles after accept.
REQ-026 Word 4 = 0x80FF7F01: lb 0x13 signed -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x10 signed -> 0x00007F01; lh 0x12 signed -> 0xFFFF80FF.
REQ-027 Request size=11 -> no mem_rena/mem_wena, resp_valid with resp_err=1 one cycle after accept.
REQ-028 Half load addr=0x11: with MAU_ALIGN_CHECK_EN -> resp_err=1, no mem_rena; without -> reads bits 15:0 of word 4, resp_err=1 never.
REQ-029 Assert rst=0 during WR of a sub-word store -> mem_wena=0 immediately, memory word unchanged, no resp_valid after release, req_ready=1.
